// File: rtl/i2s_capture_fifo_pkg.sv
// Shared types for the codec capture path: channel modes, deserialiser states
// and a small width helper.
package audio_pkg;

    typedef enum logic [1:0] {
        MODE_ALL   = 2'd0,
        MODE_SLOT0 = 2'd1,
        MODE_MONO  = 2'd2
    } capture_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SKIP  = 2'd1,
        SHIFT = 2'd2
    } cap_state_e;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Encoding 3 is reserved and behaves like "all slots".
    function automatic capture_mode_e to_mode(input logic [1:0] m);
        case (m)
            2'd1:    return MODE_SLOT0;
            2'd2:    return MODE_MONO;
            default: return MODE_ALL;
        endcase
    endfunction

endpackage

// File: rtl/i2s_capture_fifo_sync_fifo.sv
// First-word-fall-through FIFO; a write into a full FIFO succeeds only when a
// read frees the head entry in the same cycle.
module sync_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en_i,
    input  logic [DW-1:0]            wr_data_i,
    input  logic                     rd_en_i,
    output logic [DW-1:0]            rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   fill_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_wr, do_rd;

    assign empty_o   = (cnt_q == '0);
    assign full_o    = (cnt_q == (AW+1)'(DEPTH));
    assign do_rd     = rd_en_i && !empty_o;
    assign do_wr     = wr_en_i && (!full_o || do_rd);
    assign rd_data_o = mem_q[rd_ptr_q];
    assign fill_o    = cnt_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_wr, do_rd})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/i2s_capture_fifo.sv
// Oversampled TDM/I2S capture: synchronise the codec bus, deserialise NCH slots
// of W bits, apply the channel mode and queue the words in a FWFT FIFO.
module i2s_capture_fifo
    import audio_pkg::*;
#(
    parameter int W          = 16,
    parameter int NCH        = 2,
    parameter int FIFO_DEPTH = 16,
    parameter int I2S_DELAY  = 0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          bclk,
    input  logic                          adclrck,
    input  logic                          adcdat,
    input  logic                          enable,
    input  logic [1:0]                    mode,
    input  logic                          clear_flags,
    output logic [W-1:0]                  out_data,
    output logic [clog2_min1(NCH)-1:0]    out_channel,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic                          overflow,
    output logic                          frame_error
);
    localparam int CW = clog2_min1(NCH);
    localparam int LG = $clog2(NCH);
    localparam int AW = W + LG;
    localparam int BW = $clog2(W);

    typedef struct packed {
        logic [CW-1:0] channel;
        logic [W-1:0]  data;
    } fifo_entry_t;

    logic [1:0]       bclk_sync_q, lrck_sync_q, dat_sync_q;
    logic             bclk_prev_q, lrck_prev_q;
    logic             bclk_edge, lrck_rise, dat;

    cap_state_e       state_q, state_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [CW-1:0]    slot_q, slot_d;
    logic [W-2:0]     sh_q, sh_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic             en_q, en_d;
    capture_mode_e    mode_q, mode_d;
    logic             push_q, push_d;
    fifo_entry_t      push_ent_q, push_ent_d, head;
    logic             ovf_q, ovf_d, ferr_q, ferr_d;

    logic             shift_en, ferr_set, ovf_set, fifo_full, fifo_empty;
    logic [BW-1:0]    cur_bit;
    logic [CW-1:0]    cur_slot;
    logic signed [AW-1:0] cur_acc, acc_sum;
    logic             cur_en, last_slot;
    capture_mode_e    cur_mode;
    logic [W-1:0]     word;

    assign bclk_edge = bclk_sync_q[1] && !bclk_prev_q;
    assign lrck_rise = bclk_edge && lrck_sync_q[1] && !lrck_prev_q;
    assign dat       = dat_sync_q[1];

    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        slot_d     = slot_q;
        sh_d       = sh_q;
        acc_d      = acc_q;
        en_d       = en_q;
        mode_d     = mode_q;
        push_d     = 1'b0;
        push_ent_d = push_ent_q;
        shift_en   = 1'b0;
        ferr_set   = 1'b0;
        // A frame start (or restart) zeroes the counters for the bit taken on this edge.
        cur_bit    = lrck_rise ? '0 : bit_q;
        cur_slot   = lrck_rise ? '0 : slot_q;
        cur_acc    = lrck_rise ? '0 : acc_q;
        cur_en     = lrck_rise ? enable : en_q;
        cur_mode   = lrck_rise ? to_mode(mode) : mode_q;
        word       = {sh_q, dat};
        acc_sum    = cur_acc + AW'($signed(word));
        last_slot  = (cur_slot == CW'(NCH-1));

        if (lrck_rise) begin
            ferr_set = (state_q != IDLE);
            en_d     = enable;
            mode_d   = to_mode(mode);
            bit_d    = '0;
            slot_d   = '0;
            acc_d    = '0;
            if (I2S_DELAY == 0) begin
                state_d  = SHIFT;
                shift_en = 1'b1;
            end else begin
                state_d  = SKIP;
            end
        end else if (bclk_edge && state_q == SKIP) begin
            state_d  = SHIFT;
            shift_en = 1'b1;
        end else if (bclk_edge && state_q == SHIFT) begin
            shift_en = 1'b1;
        end

        if (shift_en) begin
            sh_d = word[W-2:0];
            if (cur_bit == BW'(W-1)) begin
                bit_d  = '0;
                slot_d = cur_slot + 1'b1;
                acc_d  = acc_sum;
                if (last_slot) begin
                    state_d = IDLE;
                    slot_d  = '0;
                end
                case (cur_mode)
                    MODE_MONO: begin
                        push_d     = cur_en && last_slot;
                        push_ent_d = '{channel: '0, data: W'(acc_sum >>> LG)};
                    end
                    MODE_SLOT0: begin
                        push_d     = cur_en && (cur_slot == '0);
                        push_ent_d = '{channel: cur_slot, data: word};
                    end
                    default: begin
                        push_d     = cur_en;
                        push_ent_d = '{channel: cur_slot, data: word};
                    end
                endcase
            end else begin
                bit_d = cur_bit + 1'b1;
            end
        end
    end

    // A full FIFO implies a valid head, so out_ready alone means a pop frees a slot.
    assign ovf_set = push_q && fifo_full && !out_ready;
    assign ovf_d   = ovf_set  || (ovf_q  && !clear_flags);
    assign ferr_d  = ferr_set || (ferr_q && !clear_flags);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bclk_sync_q <= '0;
            lrck_sync_q <= '0;
            dat_sync_q  <= '0;
            bclk_prev_q <= 1'b0;
            lrck_prev_q <= 1'b0;
            state_q     <= IDLE;
            bit_q       <= '0;
            slot_q      <= '0;
            sh_q        <= '0;
            acc_q       <= '0;
            en_q        <= 1'b0;
            mode_q      <= MODE_ALL;
            push_q      <= 1'b0;
            push_ent_q  <= '0;
            ovf_q       <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            bclk_sync_q <= {bclk_sync_q[0], bclk};
            lrck_sync_q <= {lrck_sync_q[0], adclrck};
            dat_sync_q  <= {dat_sync_q[0], adcdat};
            bclk_prev_q <= bclk_sync_q[1];
            if (bclk_edge) lrck_prev_q <= lrck_sync_q[1];
            state_q     <= state_d;
            bit_q       <= bit_d;
            slot_q      <= slot_d;
            sh_q        <= sh_d;
            acc_q       <= acc_d;
            en_q        <= en_d;
            mode_q      <= mode_d;
            push_q      <= push_d;
            push_ent_q  <= push_ent_d;
            ovf_q       <= ovf_d;
            ferr_q      <= ferr_d;
        end
    end

    sync_fifo #(
        .DW    ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en_i   (push_q),
        .wr_data_i (push_ent_q),
        .rd_en_i   (out_ready),
        .rd_data_o (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .fill_o    (fill_level)
    );

    assign out_valid   = !fifo_empty;
    assign out_data    = head.data;
    assign out_channel = head.channel;
    assign overflow    = ovf_q;
    assign frame_error = ferr_q;

endmodule
